register_fifo: RTL and testbench

REGISTER_FIFO -- requirements
Module: register_fifo

---
 rtl/register_fifo.sv | 96 +++++++++
 tb/tb_register_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/register_fifo.sv
// Button-driven FIFO: debounced-edge push/pop keys feed a small register file.
// Head entry, occupancy and flags come from registered state only.

module register_fifo_key (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);
  // [0],[1] form the synchroniser; [2] holds the previous synchronised level.
  logic [2:0] sync_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[1:0], key};
  end

  assign pulse = sync_pipe[1] & ~sync_pipe[2];
endmodule

module register_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       key0_i,
  input  logic                       key1_i,
  input  logic [WIDTH-1:0]           sw_i,
  output logic [WIDTH-1:0]           register_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       ovf_o,
  output logic                       udf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0] keys, pulses;
  logic       push, pop, do_push, do_pop;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             ovf_q, udf_q;

  assign keys = {key1_i, key0_i};

  for (genvar i = 0; i < 2; i++) begin : g_key
    register_fifo_key u_key (
      .clk   (clk_i),
      .rst   (rst_i),
      .key   (keys[i]),
      .pulse (pulses[i])
    );
  end

  assign push = pulses[0];
  assign pop  = pulses[1];

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

  // A pop frees the slot for a same-cycle push, so push-while-full only
  // drops when no pop accompanies it; an empty FIFO cannot service a pop.
  assign do_push = push & (~full_o | pop);
  assign do_pop  = pop & ~empty_o;

  // Storage needs no reset: it is masked from the output while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= sw_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      if (push & ~pop & full_o)  ovf_q <= 1'b1;
      if (pop & ~push & empty_o) udf_q <= 1'b1;
    end
  end

  assign register_o = empty_o ? '0 : mem[rd_ptr];
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;
  assign udf_o      = udf_q;
endmodule

// File: tb/tb_register_fifo.sv
// Randomised + directed bench: a queue-based FIFO model predicts outputs,
// a negedge monitor compares them at the predicted cycle.

module tb_register_fifo;
  localparam int W  = 10;
  localparam int D  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key0 = 1'b0, key1 = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] register_o;
  logic [CW-1:0] count_o;
  logic         empty_o, full_o, ovf_o, udf_o;

  register_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .key0_i(key0), .key1_i(key1), .sw_i(sw),
    .register_o(register_o), .count_o(count_o), .empty_o(empty_o),
    .full_o(full_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    string name;
    int    r;
    int    cnt;
    bit    emp, ful, ovf, udf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0, checks = 0;

  // Reference model: a plain queue plus sticky flags.
  int mq[$];
  bit m_ovf, m_udf;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic exp_t snap(int c, string n);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.r    = (mq.size() > 0) ? mq[0] : 0;
    e.cnt  = mq.size();
    e.emp  = (mq.size() == 0);
    e.ful  = (mq.size() == D);
    e.ovf  = m_ovf;
    e.udf  = m_udf;
    return e;
  endfunction

  task automatic model(bit ps, bit pp, int d);
    bit is_full, is_empty;
    is_full  = (mq.size() == D);
    is_empty = (mq.size() == 0);
    if (ps && pp) begin
      if (!is_empty) void'(mq.pop_front());
      mq.push_back(d);
    end else if (ps) begin
      if (is_full) m_ovf = 1'b1;
      else         mq.push_back(d);
    end else if (pp) begin
      if (is_empty) m_udf = 1'b1;
      else          void'(mq.pop_front());
    end
  endtask

  // Key goes high after edge M, is first sampled at M+1, acts at M+3.
  task automatic do_op(bit ps, bit pp, int d, int hold, string name);
    int tgt;
    @(posedge clk); #1;
    key0 = ps; key1 = pp; sw = W'(d);
    tgt = cyc + 3;
    model(ps, pp, d);
    exp_q.push_back(snap(tgt, name));
    if (hold > 3) exp_q.push_back(snap(tgt + hold - 3, {name, "_held"}));
    repeat (hold) @(posedge clk);
    #1 key0 = 1'b0; key1 = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_reg"},   register_o, 0);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_empty"}, empty_o, 1);
    chk({tag, "_full"},  full_o, 0);
    chk({tag, "_ovf"},   ovf_o, 0);
    chk({tag, "_udf"},   udf_o, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: compare every expectation at its predicted cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (!rst && exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc) chk({mon_e.name, "_late"}, cyc, mon_e.cyc);
        chk({mon_e.name, "_reg"},   register_o, mon_e.r);
        chk({mon_e.name, "_count"}, count_o,    mon_e.cnt);
        chk({mon_e.name, "_empty"}, empty_o,    mon_e.emp);
        chk({mon_e.name, "_full"},  full_o,     mon_e.ful);
        chk({mon_e.name, "_ovf"},   ovf_o,      mon_e.ovf);
        chk({mon_e.name, "_udf"},   udf_o,      mon_e.udf);
      end
    end
  end

  initial begin
    #200us;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    m_ovf = 1'b0; m_udf = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_held");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("idle");

    // Single press held for ten cycles yields one push.
    do_op(1, 0, 513, 10, "push513_hold");
    do_op(0, 1, 0, 3, "pop513");

    // Fill, overflow, drain.
    for (int i = 1; i <= 4; i++) do_op(1, 0, i, 3, $sformatf("fill%0d", i));
    do_op(1, 0, 1023, 3, "push_full");
    for (int i = 0; i < 4; i++) do_op(0, 1, 0, 3, $sformatf("drain%0d", i));

    // Underflow then push; udf stays sticky.
    do_op(0, 1, 0, 3, "pop_empty");
    do_op(1, 0, 7, 3, "push7");
    do_op(0, 1, 0, 3, "pop7");

    // Interleaved traffic to wrap the pointers.
    do_op(1, 0, 10, 3, "wrap_a");
    do_op(1, 0, 11, 3, "wrap_b");
    do_op(0, 1, 0, 3, "wrap_c");
    do_op(1, 0, 12, 3, "wrap_d");
    do_op(1, 1, 13, 3, "wrap_e");
    do_op(1, 0, 14, 3, "wrap_f");
    do_op(1, 0, 15, 3, "wrap_g");
    for (int i = 0; i < 4; i++) do_op(0, 1, 0, 3, $sformatf("wrap_pop%0d", i));
    do_op(1, 1, 21, 3, "both_empty");

    // Full with head 1, simultaneous push/pop, then reset mid-press.
    do_reset();
    for (int i = 1; i <= 4; i++) do_op(1, 0, i, 3, $sformatf("refill%0d", i));
    do_op(1, 1, 9, 3, "both_full");
    @(posedge clk); #1 key0 = 1'b1; sw = 10'd300;
    @(posedge clk); #5 rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    key0 = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      bit ps, pp;
      ps = 1'($urandom_range(0, 1));
      pp = 1'($urandom_range(0, 1));
      if (!ps && !pp) ps = 1'b1;
      do_op(ps, pp, int'($urandom_range(0, 1023)), 3, $sformatf("rand%0d", i));
    end

    repeat (5) @(posedge clk);
    chk("drain_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
